uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 67 ++++++
 rtl/uart_rx_param.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the parameterised UART receiver.
// Holds the parity-mode encoding, the receive FSM state encoding and
// the 2-of-3 majority helper used for bit voting.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  // 2-of-3 vote over the three mid-bit samples
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO holding received characters.
// Ports: clk/reset (sync, active-high), push/push_data write side,
// pop/pop_data read side (pop_data shows the head entry),
// full/empty registered status flags.
// A push on a full FIFO is ignored unless a pop happens in the same cycle;
// a pop on an empty FIFO is ignored.
module rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_pop;
  logic             do_push;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Occupancy update
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with oversampled majority voting and an
// output FIFO.
// Ports: CLOCK_50 clock, reset (sync, active-high), uart_in async serial
// line (idle high); rx_data/rx_frame_err/rx_parity_err describe the FIFO
// head entry, rx_valid = FIFO non-empty, rx_ready pops the head;
// overrun is sticky on a dropped character, cleared by ovr_clear.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 uart_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 ovr_clear
);

  localparam int unsigned DIV     = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TICK_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = $clog2(DATA_BITS);
  localparam int unsigned ENTRY_W = DATA_BITS + 2;
  localparam int unsigned MID     = OVERSAMPLE / 2;

  logic                 sync1;
  logic                 sync2;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TICK_W-1:0]    tick_cnt;
  logic [1:0]           smp;
  logic                 bit_val;
  logic                 vote_now;
  logic                 bit_end;
  rx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 ferr;
  logic                 perr;
  logic                 final_ferr;
  logic                 push;
  logic [ENTRY_W-1:0]   push_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 drop;

  // Two-flop synchroniser, resets to the idle line level
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_in;
      sync2 <= sync1;
    end
  end

  // Free-running oversample tick divider
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Third sample completes the vote; the bit ends on the last tick
  assign bit_val    = majority3({sync2, smp[1], smp[0]});
  assign vote_now   = tick && (tick_cnt == TICK_W'(MID + 1));
  assign bit_end    = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign final_ferr = ferr | ~bit_val;

  // Receive FSM
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      tick_cnt   <= '0;
      smp        <= 2'b11;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      ferr       <= 1'b0;
      perr       <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      push <= 1'b0;

      if (tick && state != ST_IDLE && state != ST_WAIT_HIGH) begin
        tick_cnt <= bit_end ? '0 : tick_cnt + TICK_W'(1);
        if (tick_cnt == TICK_W'(MID - 1)) smp[0] <= sync2;
        if (tick_cnt == TICK_W'(MID))     smp[1] <= sync2;
      end

      case (state)
        ST_IDLE: begin
          if (tick && !sync2) begin
            state    <= ST_START;
            tick_cnt <= '0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
          end
        end

        ST_START: begin
          if (vote_now && bit_val) begin
            state <= ST_IDLE;
          end else if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end

        ST_DATA: begin
          if (vote_now) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end

        ST_PARITY: begin
          if (vote_now)
            perr <= (((^shreg) ^ bit_val) != 1'(PARITY == PAR_ODD));
          if (bit_end) begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
          end
        end

        ST_STOP: begin
          // Final stop bit is decided mid-bit so the next start edge is not missed
          if (vote_now) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              push       <= 1'b1;
              push_entry <= {perr, final_ferr, shreg};
              state      <= final_ferr ? ST_WAIT_HIGH : ST_IDLE;
            end else begin
              ferr <= final_ferr;
            end
          end else if (bit_end) begin
            stop_idx <= 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          if (sync2) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO handshake; a push into a full FIFO with no pop is dropped
  assign pop  = rx_ready && !fifo_empty;
  assign drop = push && fifo_full && !pop;

  rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (rx_ready),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid      = ~fifo_empty;
  assign rx_data       = head_entry[DATA_BITS-1:0];
  assign rx_frame_err  = head_entry[DATA_BITS];
  assign rx_parity_err = head_entry[DATA_BITS+1];

  // Sticky overrun; a new drop wins over a simultaneous clear
  always_ff @(posedge CLOCK_50) begin
    if (reset)          overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
    else if (ovr_clear) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: instance u0 is 8N1, instance u1 is 8E1.
// Stimulus pushes expected {parity_err, frame_err, data} into per-instance
// queues; monitors pop and compare on every rx_valid && rx_ready handshake.
module tb_uart_rx_param;

  localparam int unsigned BIT_CLKS = 128;

  logic       clk;
  logic       reset;
  logic       line0, line1;
  logic [7:0] data0, data1;
  logic       ferr0, ferr1, perr0, perr1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic       ovr0, ovr1;
  logic       clr0, clr1;

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_param #(
    .CLK_HZ(1_228_800), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u0 (
    .CLOCK_50(clk), .reset(reset), .uart_in(line0), .rx_data(data0),
    .rx_frame_err(ferr0), .rx_parity_err(perr0), .rx_valid(valid0),
    .rx_ready(ready0), .overrun(ovr0), .ovr_clear(clr0)
  );

  uart_rx_param #(
    .CLK_HZ(1_228_800), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u1 (
    .CLOCK_50(clk), .reset(reset), .uart_in(line1), .rx_data(data1),
    .rx_frame_err(ferr1), .rx_parity_err(perr1), .rx_valid(valid1),
    .rx_ready(ready1), .overrun(ovr1), .ovr_clear(clr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare the head entry whenever it is consumed
  always @(negedge clk) begin
    if (!reset && valid0 && ready0) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL u0 unexpected entry: got 0x%0h, expected none", {perr0, ferr0, data0});
      end else begin
        check("u0 entry", 32'({perr0, ferr0, data0}), 32'(q0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && valid1 && ready1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL u1 unexpected entry: got 0x%0h, expected none", {perr1, ferr1, data1});
      end else begin
        check("u1 entry", 32'({perr1, ferr1, data1}), 32'(q1.pop_front()));
      end
    end
  end

  // Hold a line level for a number of clocks; always returns 1ns after an edge
  task automatic drive(input int which, input logic v, input int clocks);
    if (which == 0) line0 = v;
    else            line1 = v;
    repeat (clocks) @(posedge clk);
    #1;
  endtask

  // par < 0 means no parity bit
  task automatic send_frame(input int which, input logic [7:0] d, input int par, input logic stop);
    drive(which, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(which, d[i], BIT_CLKS);
    if (par >= 0) drive(which, par[0], BIT_CLKS);
    drive(which, stop, BIT_CLKS);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    line0  = 1'b1;
    line1  = 1'b1;
    ready0 = 1'b0;
    ready1 = 1'b1;
    clr0   = 1'b0;
    clr1   = 1'b0;
    cycles(4);

    // Reset state
    check("reset valid0", 32'(valid0), 32'd0);
    check("reset data0", 32'(data0), 32'd0);
    check("reset flags0", 32'({ferr0, perr0}), 32'd0);
    check("reset overrun0", 32'(ovr0), 32'd0);
    check("reset valid1", 32'(valid1), 32'd0);
    reset = 1'b0;
    cycles(40);

    // 8N1 0x41, then one-cycle pop
    q0.push_back({1'b0, 1'b0, 8'h41});
    send_frame(0, 8'h41, -1, 1'b1);
    drive(0, 1'b1, 16);
    check("0x41 valid", 32'(valid0), 32'd1);
    ready0 = 1'b1;
    cycles(1);
    ready0 = 1'b0;
    check("0x41 valid after pop", 32'(valid0), 32'd0);

    // Even parity on u1: wrong parity bit then correct one
    q1.push_back({1'b1, 1'b0, 8'h41});
    send_frame(1, 8'h41, 1, 1'b1);
    drive(1, 1'b1, 40);
    q1.push_back({1'b0, 1'b0, 8'h41});
    send_frame(1, 8'h41, 0, 1'b1);
    drive(1, 1'b1, 40);
    q1.push_back({1'b0, 1'b0, 8'hD3});
    send_frame(1, 8'hD3, 1, 1'b1);
    drive(1, 1'b1, 40);

    // Short glitch is a false start, then 0x55
    ready0 = 1'b1;
    drive(0, 1'b0, 64);
    drive(0, 1'b1, 400);
    check("glitch no push", 32'(valid0), 32'd0);
    q0.push_back({1'b0, 1'b0, 8'h55});
    send_frame(0, 8'h55, -1, 1'b1);
    drive(0, 1'b1, 40);

    // Low stop bit with a long break, then a clean frame
    q0.push_back({1'b0, 1'b1, 8'hA5});
    q0.push_back({1'b0, 1'b0, 8'h3C});
    send_frame(0, 8'hA5, -1, 1'b0);
    drive(0, 1'b0, 2000 - BIT_CLKS);
    drive(0, 1'b1, 200);
    send_frame(0, 8'h3C, -1, 1'b1);
    drive(0, 1'b1, 40);
    check("no overrun yet", 32'(ovr0), 32'd0);

    // Overrun: six frames into a depth-4 FIFO with no consumer
    ready0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) q0.push_back({2'b00, 8'(k)});
      send_frame(0, 8'(k), -1, 1'b1);
      drive(0, 1'b1, 20);
    end
    check("overrun set", 32'(ovr0), 32'd1);
    check("full valid", 32'(valid0), 32'd1);
    ready0 = 1'b1;
    cycles(10);
    ready0 = 1'b0;
    check("drained", 32'(valid0), 32'd0);
    check("overrun sticky", 32'(ovr0), 32'd1);
    clr0 = 1'b1;
    cycles(1);
    clr0 = 1'b0;
    check("overrun cleared", 32'(ovr0), 32'd0);

    // Reset in the middle of a 0xFF frame
    ready0 = 1'b1;
    drive(0, 1'b0, BIT_CLKS);
    drive(0, 1'b1, 3 * BIT_CLKS);
    reset = 1'b1;
    cycles(3);
    check("midreset outputs", 32'({valid0, ovr0, ferr0, perr0, data0}), 32'd0);
    reset = 1'b0;
    drive(0, 1'b1, 6 * BIT_CLKS);
    check("no partial char", 32'(valid0), 32'd0);
    q0.push_back({1'b0, 1'b0, 8'h12});
    send_frame(0, 8'h12, -1, 1'b1);
    drive(0, 1'b1, 60);

    check("u0 queue drained", 32'(q0.size()), 32'd0);
    check("u1 queue drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
